// File: rtl/seq_detect_if.sv
// Serial-bit handshake between a bit source and the pattern detector.
// Source drives qualifier/data/clear; detector returns match pulse, count and debug state.
interface seq_detect_if #(
   parameter int CNT_W = 8,
   parameter int ST_W  = 3
);
   logic             en;
   logic             din;
   logic             clr;
   logic             match;
   logic [CNT_W-1:0] count;
   logic             sat;
   logic [ST_W-1:0]  state_o;

   modport master (output en, din, clr, input match, count, sat, state_o);
   modport slave  (input en, din, clr, output match, count, sat, state_o);
endinterface

// File: rtl/seq_detect.sv
// KMP serial pattern detector with saturating match count; Mealy match is same-cycle, Moore is one edge later.
// No backpressure: a bit is consumed on every edge with en=1 and clr=0, otherwise everything holds.
module seq_detect #(
   parameter int             PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
   parameter bit             MOORE   = 1'b0,
   parameter bit             OVERLAP = 1'b1,
   parameter int             CNT_W   = 8
) (
   input logic        clk,
   input logic        rst_b,
   seq_detect_if.slave bus
);
   localparam int SW      = $clog2(PAT_W + 1);
   localparam int PAT_INT = int'(PATTERN);

   // Bit i of the pattern counted from the first bit received.
   function automatic int pbit(input int i);
      return (PAT_INT >> (PAT_W - 1 - i)) & 1;
   endfunction

   function automatic int delta(input int k, input int b);
      int  best;
      bit  ok;
      int  j;
      int  s;
      best = 0;
      for (int len = 1; len <= k + 1; len++) begin
         ok = 1'b1;
         for (int i = 0; i < len; i++) begin
            j = k + 1 - len + i;
            s = (j < k) ? pbit(j) : b;
            if (pbit(i) != s) ok = 1'b0;
         end
         if (ok) best = len;
      end
      return best;
   endfunction

   function automatic int border();
      int best;
      bit ok;
      best = 0;
      for (int len = 1; len < PAT_W; len++) begin
         ok = 1'b1;
         for (int i = 0; i < len; i++) begin
            if (pbit(i) != pbit(PAT_W - len + i)) ok = 1'b0;
         end
         if (ok) best = len;
      end
      return best;
   endfunction

   localparam int            RESTART = OVERLAP ? border() : 0;
   localparam logic [SW-1:0] RST_ST  = RESTART[SW-1:0];
   localparam logic [SW-1:0] FULL    = PAT_W[SW-1:0];

   // Row PAT_W is only reachable in Moore mode: it resumes from the restart point.
   logic [SW-1:0] nxt_tbl [0:PAT_W][0:1];

   for (genvar gk = 0; gk <= PAT_W; gk++) begin : g_row
      for (genvar gb = 0; gb < 2; gb++) begin : g_bit
         localparam int KS = (gk < PAT_W) ? gk : RESTART;
         localparam int NX = delta(KS, gb);
         assign nxt_tbl[gk][gb] = NX[SW-1:0];
      end
   end

   logic [SW-1:0]    state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             match_q, match_d;
   logic [SW-1:0]    nxt;
   logic             accept;
   logic             hit;
   logic             sat;

   assign sat = &count_q;

   always_comb begin
      nxt     = nxt_tbl[state_q][bus.din];
      accept  = bus.en && !bus.clr;
      hit     = accept && (nxt == FULL);
      state_d = state_q;
      count_d = count_q;
      match_d = match_q;
      if (bus.clr) begin
         state_d = '0;
         count_d = '0;
         match_d = 1'b0;
      end else if (bus.en) begin
         state_d = (hit && !MOORE) ? RST_ST : nxt;
         match_d = hit;
         if (hit && !sat) count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= '0;
         count_q <= '0;
         match_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         match_q <= match_d;
      end
   end

   assign bus.match   = MOORE ? match_q : hit;
   assign bus.count   = count_q;
   assign bus.sat     = sat;
   assign bus.state_o = state_q;
endmodule
